// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncer: FSM state encodings
// and default timing parameters.
package debounce_pkg;

  localparam int DEFAULT_STABLE_COUNT = 250000;  // 5 ms at 50 MHz
  localparam int DEFAULT_CNT_WIDTH    = 18;

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] HOLD_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous button level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-FF synchronizer, 4-state stability FSM, press pulse.
// Optional release pulse enabled by defining DEBOUNCE_RELEASE_PULSE_EN.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_rel_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_COUNT - 1);

  logic                 s;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 press_accept;
  logic                 rel_accept;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s)
  );

  assign press_accept = (state == WAIT_HIGH) &&  s && (cnt == CNT_MAX);
  assign rel_accept   = (state == WAIT_LOW)  && !s && (cnt == CNT_MAX);

  // The state leaves WAIT_* exactly at CNT_MAX, so cnt can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      btn_pulse <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state <= IDLE_LOW;
          end else if (press_accept) begin
            state     <= HOLD_HIGH;
            btn_level <= 1'b1;
            btn_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD_HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        default: begin  // WAIT_LOW
          if (s) begin
            state <= HOLD_HIGH;
          end else if (rel_accept) begin
            state     <= IDLE_LOW;
            btn_level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_rel_pulse <= 1'b0;
    end else begin
      btn_rel_pulse <= rel_accept;
    end
  end
`else
  assign btn_rel_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (STABLE_COUNT=4, CNT_WIDTH=3):
// directed scenarios plus random stimulus against a run-length reference model.
module tb_button_debouncer;

  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_pulse;
  logic btn_rel_pulse;

  int checks   = 0;
  int failures = 0;

  // Reference model state: raw samples waiting to emerge from the synchronizer,
  // accepted level, and length of the current run of samples disagreeing with it.
  logic dly[$];
  logic exp_level = 1'b0;
  logic exp_pulse = 1'b0;
  logic exp_rel   = 1'b0;
  int   run       = 0;

  button_debouncer #(.STABLE_COUNT(SC), .CNT_WIDTH(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .btn_pulse     (btn_pulse),
    .btn_rel_pulse (btn_rel_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A level change is accepted once the synchronized input has disagreed with
  // the accepted level for SC+1 consecutive samples (entry sample + SC counts).
  task automatic model_edge(input logic b, input logic r);
    logic s;
    exp_pulse = 1'b0;
    exp_rel   = 1'b0;
    if (r) begin
      dly       = '{1'b0, 1'b0};
      exp_level = 1'b0;
      run       = 0;
    end else begin
      s = dly.pop_front();
      dly.push_back(b);
      if (s != exp_level) run++;
      else                run = 0;
      if (run == SC + 1) begin
        exp_level = s;
        exp_pulse = s;
        exp_rel   = !s;
        run       = 0;
      end
    end
`ifndef DEBOUNCE_RELEASE_PULSE_EN
    exp_rel = 1'b0;
`endif
  endtask

  task automatic cycle(input logic b, input logic r);
    btn_in = b;
    rst    = r;
    @(posedge clk);
    #1;
    model_edge(b, r);
    check("btn_level", int'(btn_level), int'(exp_level));
    check("btn_pulse", int'(btn_pulse), int'(exp_pulse));
    check("btn_rel_pulse", int'(btn_rel_pulse), int'(exp_rel));
  endtask

  // Hold btn_in for n edges; report first edge (1-based) at which btn_level
  // departs from the model's level at entry, and pulses seen.
  task automatic hold(input logic b, input int n, output int first_change,
                      output int presses, output int releases);
    logic start;
    start        = exp_level;
    first_change = -1;
    presses      = 0;
    releases     = 0;
    for (int i = 1; i <= n; i++) begin
      cycle(b, 1'b0);
      if (first_change < 0 && btn_level !== start) first_change = i;
      if (btn_pulse === 1'b1)     presses++;
      if (btn_rel_pulse === 1'b1) releases++;
    end
  endtask

  initial begin
    int fc, np, nr, len, exp_rel_cnt;
    logic b;
    dly = '{1'b0, 1'b0};
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    exp_rel_cnt = 1;
`else
    exp_rel_cnt = 0;
`endif

    // Reset for 3 edges with button held high; outputs must stay 0.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    check("reset_level", int'(btn_level), 0);
    check("reset_pulse", int'(btn_pulse), 0);
    hold(1'b1, 12, fc, np, nr);
    check("post_reset_accept_edge", fc, 7);
    check("post_reset_press_count", np, 1);

    // Release from level 1.
    hold(1'b0, 12, fc, np, nr);
    check("release_edge", fc, 7);
    check("release_rel_pulses", nr, exp_rel_cnt);
    check("release_press_pulses", np, 0);

    // Clean press.
    hold(1'b1, 12, fc, np, nr);
    check("press_edge", fc, 7);
    check("press_pulses", np, 1);
    hold(1'b0, 12, fc, np, nr);

    // Short 3-cycle glitch: no output change.
    hold(1'b1, 3, fc, np, nr);
    check("glitch_hi_change", fc, -1);
    check("glitch_hi_pulses", np, 0);
    hold(1'b0, 10, fc, np, nr);
    check("glitch_lo_change", fc, -1);
    check("glitch_lo_pulses", np + nr, 0);

    // Bounce 1,0,1,0 then steady 1: single pulse 7 edges after last 0->1.
    for (int i = 0; i < 2; i++) begin
      hold(1'b1, 1, fc, np, nr);
      check("bounce_hi_pulses", np, 0);
      hold(1'b0, 1, fc, np, nr);
      check("bounce_lo_pulses", np, 0);
    end
    hold(1'b1, 12, fc, np, nr);
    check("bounce_accept_edge", fc, 7);
    check("bounce_press_pulses", np, 1);
    hold(1'b0, 12, fc, np, nr);

    // Reset at edge 5 of a pending press aborts; re-accept 7 edges after release.
    hold(1'b1, 4, fc, np, nr);
    check("abort_pre_pulses", np, 0);
    cycle(1'b1, 1'b1);
    check("abort_rst_pulse", int'(btn_pulse), 0);
    check("abort_rst_level", int'(btn_level), 0);
    hold(1'b1, 12, fc, np, nr);
    check("abort_reaccept_edge", fc, 7);
    check("abort_reaccept_pulses", np, 1);

    // Reset while held high drops level with no pulse of either kind.
    cycle(1'b1, 1'b1);
    check("hold_rst_level", int'(btn_level), 0);
    check("hold_rst_rel", int'(btn_rel_pulse), 0);
    hold(1'b0, 10, fc, np, nr);

    // Random bursts with occasional reset, checked every edge by the model.
    for (int k = 0; k < 200; k++) begin
      b   = logic'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) cycle(b, ($urandom_range(0, 40) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
